// File: rtl/fp_pkg.sv
// Shared IEEE 754 single-precision field constants and result-entry types.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fp_pkg;

    localparam int EXP_W       = 8;
    localparam int MAN_W       = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int ENTRY_TAG_W = 3;
    localparam int DEPTH       = 2;

    // One-hot (or all-zero for a normal number) classification of a result.
    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic subnormal;
    } fp_class_t;

    // One buffered result with its flags, tag and precomputed class.
    typedef struct packed {
        logic [31:0]            result;
        logic                   overflow;
        logic                   underflow;
        logic [ENTRY_TAG_W-1:0] tag;
        fp_class_t              cls;
    } fp_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Classifies a single-precision value as nan/inf/zero/subnormal (all zero = normal).
// Latency: combinational.
// Backpressure: not applicable.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] fp_in,
    output fp_class_t   fp_cls
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             man_nz;

    assign exp_f  = fp_in[30:23];
    assign man_f  = fp_in[22:0];
    assign man_nz = |man_f;

    // Sign bit is ignored; exponent extremes select the special classes.
    always_comb begin
        fp_cls           = '0;
        fp_cls.nan       = (exp_f == EXP_MAX) &  man_nz;
        fp_cls.inf       = (exp_f == EXP_MAX) & ~man_nz;
        fp_cls.zero      = (exp_f == '0)      & ~man_nz;
        fp_cls.subnormal = (exp_f == '0)      &  man_nz;
    end

endmodule

// File: rtl/fp_result_buffer.sv
// Two-entry skid buffer for add/sub results with class, sticky flags and result counter.
// Latency: one cycle from accepted input to out_valid when empty.
// Backpressure: in_ready drops only when both entries hold data; it never looks at out_ready.
module fp_result_buffer
    import fp_pkg::*;
#(
    parameter int TAG_W = fp_pkg::ENTRY_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_overflow,
    input  logic             in_underflow,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_class,
    input  logic             flags_clr,
    output logic             flag_of,
    output logic             flag_uf,
    output logic [CNT_W-1:0] res_cnt
);

    fp_entry_t        mem_q [DEPTH];
    fp_entry_t        mem_d [DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             flag_of_q, flag_of_d;
    logic             flag_uf_q, flag_uf_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    fp_class_t        in_cls;
    fp_entry_t        new_entry;
    fp_entry_t        head;
    logic             push;
    logic             pop;

    fp_classify u_classify (
        .fp_in  (in_result),
        .fp_cls (in_cls)
    );

    // Ready depends only on reset and stored occupancy so upstream timing is isolated.
    assign in_ready  = ~rst & (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign new_entry.result    = in_result;
    assign new_entry.overflow  = in_overflow;
    assign new_entry.underflow = in_underflow;
    assign new_entry.tag       = ENTRY_TAG_W'(in_tag);
    assign new_entry.cls       = in_cls;

    assign head          = mem_q[rd_ptr_q];
    assign out_result    = head.result;
    assign out_overflow  = head.overflow;
    assign out_underflow = head.underflow;
    assign out_tag       = TAG_W'(head.tag);
    assign out_class     = head.cls;

    assign flag_of = flag_of_q;
    assign flag_uf = flag_uf_q;
    assign res_cnt = res_cnt_q;

    // Next-state: storage write, pointer/occupancy update, sticky flags, saturating count.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        flag_of_d = flag_of_q;
        flag_uf_d = flag_uf_q;
        res_cnt_d = res_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Clear takes effect before the pushed flags are merged in.
        if (flags_clr) begin
            flag_of_d = 1'b0;
            flag_uf_d = 1'b0;
        end
        if (push) begin
            flag_of_d = flag_of_d | in_overflow;
            flag_uf_d = flag_uf_d | in_underflow;
        end

        if (push && (res_cnt_q != {CNT_W{1'b1}})) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards stored entries and zeroes the head fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            flag_of_q <= 1'b0;
            flag_uf_q <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            flag_of_q <= flag_of_d;
            flag_uf_q <= flag_uf_d;
            res_cnt_q <= res_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed vector bench for fp_result_buffer, with a narrow-counter instance for saturation.
// Latency: checks one cycle after each applied row.
// Backpressure: exercised via out_ready stalls and a full buffer.
module tb_fp_result_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic [2:0]  in_tag;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_result, out_result2;
    logic        out_overflow, out_overflow2;
    logic        out_underflow, out_underflow2;
    logic [2:0]  out_tag, out_tag2;
    logic [3:0]  out_class, out_class2;
    logic        flags_clr;
    logic        flag_of, flag_of2;
    logic        flag_uf, flag_uf2;
    logic [15:0] res_cnt;
    logic [1:0]  res_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    fp_result_buffer #(.TAG_W(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow),
        .out_tag(out_tag), .out_class(out_class), .flags_clr(flags_clr),
        .flag_of(flag_of), .flag_uf(flag_uf), .res_cnt(res_cnt)
    );

    fp_result_buffer #(.TAG_W(3), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_result(in_result), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .in_tag(in_tag), .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .out_overflow(out_overflow2), .out_underflow(out_underflow2),
        .out_tag(out_tag2), .out_class(out_class2), .flags_clr(flags_clr),
        .flag_of(flag_of2), .flag_uf(flag_uf2), .res_cnt(res_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] data;
        logic        of;
        logic        uf;
        logic [2:0]  tag;
        logic        ordy;
        logic        clr;
        logic        e_ov;
        logic [31:0] e_res;
        logic [3:0]  e_cls;
        logic [2:0]  e_tag;
        logic        e_ir;
        logic        e_fof;
        logic        e_fuf;
        int          e_rc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic iv, input logic [31:0] d, input logic of, input logic uf,
        input logic [2:0] tg, input logic ordy, input logic clr,
        input logic e_ov, input logic [31:0] e_res, input logic [3:0] e_cls, input logic [2:0] e_tag,
        input logic e_ir, input logic e_fof, input logic e_fuf, input int e_rc);
        vec_t v;
        v.rst = r; v.iv = iv; v.data = d; v.of = of; v.uf = uf; v.tag = tg;
        v.ordy = ordy; v.clr = clr; v.e_ov = e_ov; v.e_res = e_res; v.e_cls = e_cls;
        v.e_tag = e_tag; v.e_ir = e_ir; v.e_fof = e_fof; v.e_fuf = e_fuf; v.e_rc = e_rc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic of,
                         input logic uf, input logic [2:0] tg, input logic ordy, input logic clr);
        rst = r; in_valid = iv; in_result = d; in_overflow = of; in_underflow = uf;
        in_tag = tg; out_ready = ordy; flags_clr = clr;
    endtask

    initial begin
        int exp_sat;

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // reset
        vecs.push_back(mk(1,0,32'h0,0,0,0,0,0,       0,32'h0,4'b0000,0,       0,0,0,0));
        // single transfer
        vecs.push_back(mk(0,1,32'h3F800000,0,0,5,1,0, 1,32'h3F800000,4'b0000,5, 1,0,0,1));
        vecs.push_back(mk(0,0,32'h0,0,0,0,1,0,       0,32'h0,4'b0000,0,       1,0,0,1));
        // backpressure and ordering
        vecs.push_back(mk(0,1,32'h40000000,0,0,1,0,0, 1,32'h40000000,4'b0000,1, 1,0,0,2));
        vecs.push_back(mk(0,1,32'h7F800000,0,0,2,0,0, 1,32'h40000000,4'b0000,1, 0,0,0,3));
        vecs.push_back(mk(0,1,32'h00000000,0,0,3,0,0, 1,32'h40000000,4'b0000,1, 0,0,0,3));
        vecs.push_back(mk(0,1,32'h00000000,0,0,3,1,0, 1,32'h7F800000,4'b0100,2, 1,0,0,3));
        vecs.push_back(mk(0,1,32'h00000000,0,0,3,1,0, 1,32'h00000000,4'b0010,3, 1,0,0,4));
        vecs.push_back(mk(0,0,32'h0,0,0,0,1,0,       0,32'h0,4'b0000,0,       1,0,0,4));
        // streaming push+pop at occupancy 1
        vecs.push_back(mk(0,1,32'h3F800000,0,0,0,1,0, 1,32'h3F800000,4'b0000,0, 1,0,0,5));
        vecs.push_back(mk(0,1,32'hBF800000,0,0,1,1,0, 1,32'hBF800000,4'b0000,1, 1,0,0,6));
        vecs.push_back(mk(0,1,32'h41200000,0,0,2,1,0, 1,32'h41200000,4'b0000,2, 1,0,0,7));
        vecs.push_back(mk(0,0,32'h0,0,0,0,1,0,       0,32'h0,4'b0000,0,       1,0,0,7));
        // sticky flags
        vecs.push_back(mk(0,1,32'h7F800000,1,0,0,1,0, 1,32'h7F800000,4'b0100,0, 1,1,0,8));
        vecs.push_back(mk(0,1,32'h3F800000,0,0,0,1,0, 1,32'h3F800000,4'b0000,0, 1,1,0,9));
        vecs.push_back(mk(0,1,32'h40000000,0,0,0,1,0, 1,32'h40000000,4'b0000,0, 1,1,0,10));
        vecs.push_back(mk(0,0,32'h0,0,0,0,1,1,       0,32'h0,4'b0000,0,       1,0,0,10));
        vecs.push_back(mk(0,1,32'h3F800000,1,0,4,1,0, 1,32'h3F800000,4'b0000,4, 1,1,0,11));
        vecs.push_back(mk(0,1,32'h00000001,0,1,6,1,1, 1,32'h00000001,4'b0001,6, 1,0,1,12));
        // classification
        vecs.push_back(mk(0,1,32'h7FC00000,0,0,0,1,0, 1,32'h7FC00000,4'b1000,0, 1,0,1,13));
        vecs.push_back(mk(0,1,32'h80000000,0,0,7,1,0, 1,32'h80000000,4'b0010,7, 1,0,1,14));
        vecs.push_back(mk(0,0,32'h0,0,0,0,1,0,       0,32'h0,4'b0000,0,       1,0,1,14));
        // reset while full
        vecs.push_back(mk(0,1,32'h40400000,1,0,1,0,0, 1,32'h40400000,4'b0000,1, 1,1,1,15));
        vecs.push_back(mk(0,1,32'h40800000,0,0,2,0,0, 1,32'h40400000,4'b0000,1, 0,1,1,16));
        vecs.push_back(mk(1,1,32'h40A00000,0,0,3,0,0, 0,32'h0,4'b0000,0,       0,0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,0,0,1,0,       0,32'h0,4'b0000,0,       1,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].data, vecs[i].of, vecs[i].uf,
                  vecs[i].tag, vecs[i].ordy, vecs[i].clr);
            @(posedge clk);
            #1;
            exp_sat = (vecs[i].e_rc > 3) ? 3 : vecs[i].e_rc;
            chk($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("row%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
            chk($sformatf("row%0d flag_of", i),   {31'd0, flag_of},   {31'd0, vecs[i].e_fof});
            chk($sformatf("row%0d flag_uf", i),   {31'd0, flag_uf},   {31'd0, vecs[i].e_fuf});
            chk($sformatf("row%0d res_cnt", i),   {16'd0, res_cnt},   32'(vecs[i].e_rc));
            chk($sformatf("row%0d res_cnt_sat", i), {30'd0, res_cnt2}, 32'(exp_sat));
            if (vecs[i].e_ov) begin
                chk($sformatf("row%0d out_result", i), out_result, vecs[i].e_res);
                chk($sformatf("row%0d out_class", i), {28'd0, out_class}, {28'd0, vecs[i].e_cls});
                chk($sformatf("row%0d out_tag", i),   {29'd0, out_tag},   {29'd0, vecs[i].e_tag});
            end
        end

        // Head fields were wiped by reset.
        chk("rst out_result", out_result, 32'h0);
        chk("rst out_tag", {29'd0, out_tag}, 32'h0);
        chk("rst out_class", {28'd0, out_class}, 32'h0);
        chk("rst out_overflow", {31'd0, out_overflow}, 32'h0);

        // Discarded entries must never reappear.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d out_valid", k), {31'd0, out_valid}, 32'h0);
        end

        // Fill both entries under stall, then check in_ready ignores out_ready.
        drive(1'b0, 1'b1, 32'h40490FDB, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h00800000, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("full head result", out_result, 32'h40490FDB);
        chk("full head underflow", {31'd0, out_underflow}, 32'h1);
        chk("full head overflow", {31'd0, out_overflow}, 32'h0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("full in_ready vs out_ready", {31'd0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("drain2 result", out_result, 32'h00800000);
        chk("drain2 class", {28'd0, out_class}, 32'h0);
        chk("drain2 tag", {29'd0, out_tag}, 32'd4);
        chk("drain2 overflow", {31'd0, out_overflow}, 32'h1);
        chk("drain2 in_ready", {31'd0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("drain end out_valid", {31'd0, out_valid}, 32'h0);
        chk("drain end res_cnt", {16'd0, res_cnt}, 32'd2);
        chk("drain end flags", {30'd0, flag_of, flag_uf}, 32'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_result_buffer.md
Name: fp_result_buffer

Overview:
- Registered output stage directly downstream of the combinational add/sub datapath (A+B, A−B via sign-flip and adder).
- Captures each IEEE 754 single-precision result with its overflow/underflow flags into a 2-entry skid buffer under a valid/ready handshake.
- Classifies each result and keeps sticky exception flags plus a saturating result counter for the FP ALU status interface.

Parameters:
- TAG_W, 3: width of the opaque tag carried with each result (e.g. opcode or r_mode); passed through unchanged.
- CNT_W, 16: width of the saturating accepted-result counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  buffer can accept this cycle.
- in_result  in  32  IEEE 754 single result from the adder/subtractor.
- in_overflow  in  1  overflow flag for in_result.
- in_underflow  in  1  underflow flag for in_result.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_result  out  32  head result.
- out_overflow  out  1  head overflow flag.
- out_underflow  out  1  head underflow flag.
- out_tag  out  TAG_W  head tag.
- out_class  out  4  {nan, inf, zero, subnormal} of head; all 0 = normal.
- flags_clr  in  1  clear sticky flags.
- flag_of  out  1  sticky overflow.
- flag_uf  out  1  sticky underflow.
- res_cnt  out  CNT_W  saturating count of accepted inputs.

Behaviour:
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: 2 entries, FIFO order strictly preserved; occupancy count ∈ {0,1,2}.
- in_ready = ~rst & (count != 2). Depends on registered state only; no combinational path from out_ready.
- Latency: result pushed in cycle N is visible on out_* with out_valid=1 in cycle N+1 (when the buffer was empty).
- out_valid = (count != 0). out_* always driven from the head entry. Head fields are stable while out_valid=1 & out_ready=0.
- Occupancy transitions:
  - count 0: push → 1.
  - count 1: push only → 2; pop only → 0; push+pop → 1, new entry becomes head next cycle.
  - count 2: no push possible; pop → 1.
- out_class is computed at push time from in_result and stored with the entry:
  - nan: exp=0xFF, man≠0.
  - inf: exp=0xFF, man=0.
  - zero: exp=0, man=0.
  - subnormal: exp=0, man≠0.
  - At most one bit is set. Sign is ignored.
- Sticky flags:
  - On push: flag_of |= in_overflow, flag_uf |= in_underflow.
  - flags_clr with no push: both clear to 0.
  - flags_clr and push in the same cycle: flags take exactly the pushed entry's flags (clear happens first, then set).
  - Flags are not affected by pop.
- res_cnt increments by 1 on each push and saturates at 2^CNT_W−1 (no wrap). It is not cleared by flags_clr.
- Reset (any cycle, including mid-transfer with full buffer):
  - Next cycle: count=0, out_valid=0, flag_of=0, flag_uf=0, res_cnt=0.
  - out_result/out_tag/out_class/out_overflow/out_underflow = 0.
  - Stored entries are discarded.
  - in_ready=0 while rst=1.
- in_valid with in_ready=0: the input is not captured. Upstream must hold its data; the block does not check this.

Decomposition:
- Package fp_pkg holds:
  - Constants: EXP_W=8, MAN_W=23, EXP_MAX=8'hFF.
  - typedef fp_class_t (4-bit packed struct {nan, inf, zero, subnormal}).
  - typedef fp_entry_t {result, overflow, underflow, tag, class}.
- One combinational sub-module, fp_classify (32-bit in → fp_class_t), reusable by the future compare/classify unit.

Test Plan:
- Single transfer: push 0x3F800000, flags 0, tag 3'b101, out_ready=1 → next cycle out_valid=1, out_result=0x3F800000, out_tag=101, out_class=0000, res_cnt=1; following cycle out_valid=0.
- Backpressure and order:
  - Stimulus: out_ready=0; offer 0x40000000, 0x7F800000, 0x00000000 on consecutive cycles.
  - First two accepted; in_ready=0 after the second; third is held.
  - Then out_ready=1 → outputs in order 0x40000000/0000, 0x7F800000/0100, 0x00000000/0010; res_cnt=3.
- Simultaneous push+pop at count 1: continuous stream 0x3F800000, 0xBF800000, 0x41200000 with out_ready=1 → count stays 1, one result per cycle, in order, in_ready constantly 1.
- Sticky flags:
  - Push 0x7F800000 with overflow=1, then two clean pushes → flag_of=1.
  - flags_clr → flag_of=0.
  - flags_clr plus push 0x00000001 with underflow=1 → flag_uf=1, flag_of=0, out_class=0001.
- Classification/NaN and counter saturation:
  - 0x7FC00000 → out_class=1000; 0x80000000 → 0010.
  - With CNT_W=2, five pushes → res_cnt=3.
- Reset mid-operation: fill both entries with out_ready=0, set flag_of, assert rst one cycle → next cycle out_valid=0, out_result=0, flag_of=0, res_cnt=0, in_ready=1; old entries never appear on out_*.
